// File: rtl/sbox_output_collector.sv
// Masked AES S-box output stage: per-share linear output map, then packing of four bytes into column words.
// Optional macro SBOX_OUT_REFRESH_EN applies a 2-random mask refresh to each completed column.
module sbox_output_collector #(
  parameter logic [63:0] OUT_MAT = 64'hF87C3E1F8FC7E3F1,
  parameter logic [7:0]  AFF_C   = 8'h63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        start,
  input  logic [7:0]  y1,
  input  logic [7:0]  y2,
  input  logic [7:0]  y3,
  input  logic [63:0] r_ref,
  output logic        out_valid,
  output logic [31:0] w1,
  output logic [31:0] w2,
  output logic [31:0] w3,
  output logic [1:0]  fill
);

  // Output bit i is the parity of matrix row i masked by the input byte.
  function automatic logic [7:0] lin_map(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = ^(OUT_MAT[8*i +: 8] & x);
    end
    return r;
  endfunction

  logic [7:0]  a1, a2, a3;
  logic        a_valid, a_start;
  logic [31:0] col1, col2, col3;
  logic [31:0] m1, m2, m3;
  logic [31:0] nw1, nw2, nw3;
  logic [1:0]  slot;
  logic        last;

  // Stage A control. The affine constant enters share 1 only.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_start <= 1'b0;
    end else begin
      a_valid <= in_valid;
      a_start <= start & in_valid;
    end
  end

  // NOTE: data-only registers carry no reset; their contents are qualified by a_valid / fill.
  always_ff @(posedge clk) begin
    a1 <= lin_map(y1) ^ AFF_C;
    a2 <= lin_map(y2);
    a3 <= lin_map(y3);
  end

  // Slot selection and byte merge into the partial column of each share.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    slot = a_start ? 2'd0 : fill;
    m1   = col1;
    m2   = col2;
    m3   = col3;
    m1[8*slot +: 8] = a1;
    m2[8*slot +: 8] = a2;
    m3[8*slot +: 8] = a3;
    last = a_valid && (slot == 2'd3);
  end

`ifdef SBOX_OUT_REFRESH_EN
  // Share 3 absorbs both randoms so the XOR of the three shares is unchanged.
  assign nw1 = m1 ^ r_ref[31:0];
  assign nw2 = m2 ^ r_ref[63:32];
  assign nw3 = m3 ^ r_ref[31:0] ^ r_ref[63:32];
`else
  logic unused_r_ref;
  assign unused_r_ref = ^r_ref;
  assign nw1 = m1;
  assign nw2 = m2;
  assign nw3 = m3;
`endif

  always_ff @(posedge clk) begin
    if (a_valid) begin
      col1 <= m1;
      col2 <= m2;
      col3 <= m3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      fill      <= 2'd0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
    end else begin
      out_valid <= last;
      if (a_valid) begin
        fill <= (slot == 2'd3) ? 2'd0 : slot + 2'd1;
      end
      if (last) begin
        w1 <= nw1;
        w2 <= nw2;
        w3 <= nw3;
      end
    end
  end

endmodule

// File: tb/tb_sbox_output_collector.sv
// Self-checking bench for sbox_output_collector: directed column scenarios plus randomized traffic
// checked against a byte-queue model of the S-box output collector.
module tb_sbox_output_collector;

  logic        clk = 1'b0;
  logic        rst, in_valid, start;
  logic [7:0]  y1, y2, y3;
  logic [63:0] r_ref;
  logic        out_valid;
  logic [31:0] w1, w2, w3;
  logic [1:0]  fill;

  sbox_output_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .start(start),
    .y1(y1), .y2(y2), .y3(y3), .r_ref(r_ref),
    .out_valid(out_valid), .w1(w1), .w2(w2), .w3(w3), .fill(fill)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  q1[$], q2[$], q3[$], qs[$];
  logic [31:0] ew1 = '0, ew2 = '0, ew3 = '0, ecol = '0;
  logic        eov = 1'b0;
  int          efill = 0;
  logic        p_v = 1'b0, p_s = 1'b0;
  logic [7:0]  p1, p2, p3, px;
  logic [63:0] rr = '0;
  int          pulses;

  // AES affine linear part, written bitwise: b_i = x_i ^ x_i+4 ^ x_i+5 ^ x_i+6 ^ x_i+7 (mod 8)
  function automatic logic [7:0] aff_lin(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_apply();
    if (p_s) begin
      q1.delete(); q2.delete(); q3.delete(); qs.delete();
    end
    q1.push_back(aff_lin(p1) ^ 8'h63);
    q2.push_back(aff_lin(p2));
    q3.push_back(aff_lin(p3));
    qs.push_back(aff_lin(px) ^ 8'h63);
    if (q1.size() == 4) begin
      ew1  = {q1[3], q1[2], q1[1], q1[0]};
      ew2  = {q2[3], q2[2], q2[1], q2[0]};
      ew3  = {q3[3], q3[2], q3[1], q3[0]};
      ecol = {qs[3], qs[2], qs[1], qs[0]};
`ifdef SBOX_OUT_REFRESH_EN
      ew1 = ew1 ^ rr[31:0];
      ew2 = ew2 ^ rr[63:32];
      ew3 = ew3 ^ rr[31:0] ^ rr[63:32];
`endif
      eov = 1'b1;
      q1.delete(); q2.delete(); q3.delete(); qs.delete();
    end
    efill = q1.size();
  endtask

  // One clock: drive inputs (x = unmasked inversion value, m1/m2 = masks), advance, update model, compare.
  task automatic cyc(input logic r, input logic v, input logic s,
                     input logic [7:0] x, input logic [7:0] m1, input logic [7:0] m2);
    rst = r; in_valid = v; start = s; r_ref = rr;
    y1 = x ^ m1 ^ m2; y2 = m1; y3 = m2;
    @(posedge clk); #1;
    eov = 1'b0;
    if (r) begin
      q1.delete(); q2.delete(); q3.delete(); qs.delete();
      ew1 = '0; ew2 = '0; ew3 = '0; efill = 0; p_v = 1'b0;
    end else begin
      if (p_v) model_apply();
      p_v = v; p_s = s & v; p1 = x ^ m1 ^ m2; p2 = m1; p3 = m2; px = x;
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, eov});
    check("fill", {30'b0, fill}, efill[31:0]);
    check("w1", w1, ew1);
    check("w2", w2, ew2);
    check("w3", w3, ew3);
    if (eov) check("unmasked_col", w1 ^ w2 ^ w3, ecol);
    if (out_valid) pulses++;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int ov_cycle;
    logic [7:0] col_in [4];

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_w1", w1, 32'd0);

    // Four bytes (0x01,0,0): column 0x7C7C7C7C two cycles after the 4th byte
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00);
    idle();
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_xor", w1 ^ w2 ^ w3, 32'h7C7C7C7C);
    idle();

    // Masked column of inverse values {00,01,8D,CA}: S-box outputs 63,7C,77,ED
    col_in[0] = 8'h00; col_in[1] = 8'h01; col_in[2] = 8'h8D; col_in[3] = 8'hCA;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, col_in[i], 8'($urandom), 8'($urandom));
    idle();
    check("t2_xor", w1 ^ w2 ^ w3, 32'hED777C63);
    idle();

    // Bytes at cycles 0,3,4,9 with gaps: one out_valid at cycle 11
    pulses = 0; ov_cycle = -1;
    for (int c = 0; c < 14; c++) begin
      cyc(1'b0, (c == 0 || c == 3 || c == 4 || c == 9), 1'b0,
          8'($urandom), 8'($urandom), 8'($urandom));
      if (out_valid && ov_cycle < 0) ov_cycle = c + 1;
    end
    check("gap_pulses", pulses, 32'd1);
    check("gap_ov_cycle", ov_cycle, 32'd11);

    // Start on the third byte discards the partial column
    pulses = 0;
    cyc(1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
    cyc(1'b0, 1'b1, 1'b0, 8'h44, 8'h55, 8'h66);
    cyc(1'b0, 1'b1, 1'b1, 8'h77, 8'h88, 8'h99);
    idle();
    check("start_fill", {30'b0, fill}, 32'd1);
    check("start_no_pulse", pulses, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    idle();
    check("start_complete", {31'b0, out_valid}, 32'd1);
    idle();

    // Reset mid-column clears outputs and fill
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    cyc(1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h00);
    check("rst_w1", w1, 32'd0);
    check("rst_fill", {30'b0, fill}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    idle(); idle();

    // Zero-mask column 0x63636363 with fixed r_ref
    rr = 64'hA5A5A5A5_3C3C3C3C;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    idle();
`ifdef SBOX_OUT_REFRESH_EN
    check("ref_w1", w1, 32'h5F5F5F5F);
    check("ref_w2", w2, 32'hA5A5A5A5);
    check("ref_w3", w3, 32'h99999999);
`else
    check("ref_w1", w1, 32'h63636363);
    check("ref_w2", w2, 32'h00000000);
`endif
    check("ref_xor", w1 ^ w2 ^ w3, 32'h63636363);

    // Randomized traffic with occasional start and reset
    for (int c = 0; c < 600; c++) begin
      rr = {$urandom, $urandom};
      cyc(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
          8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
